// File: rtl/video_hsmooth3_if.sv
// Avalon-ST style video stream bundle: one 24-bit word with packet framing.
//   data   24  {R,G,B} pixel or packet header word
//   valid  1   word valid (master -> slave)
//   ready  1   slave accepts the word this cycle (slave -> master)
//   sop    1   start of packet
//   eop    1   end of packet
interface video_hsmooth3_if;
  logic [23:0] data;
  logic        valid;
  logic        ready;
  logic        sop;
  logic        eop;

  modport master (output data, output valid, output sop, output eop, input ready);
  modport slave  (input data, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/video_hsmooth3.sv
// Horizontal [1 2 1]/4 smoothing pre-filter for an Avalon-ST RGB video stream.
// Video packets (header nibble 0) are filtered per channel with edge replication at both
// line ends; all other packets are forwarded untouched. One output register, 1-cycle
// latency, and one sink stall cycle per line while the last column is flushed.
//   clk      clock
//   reset_n  synchronous active-low reset
//   enable   filter enable, sampled on the sop word only
//   sink     input stream (slave)
//   source   output stream (master)
module video_hsmooth3 #(
  parameter int unsigned IMAGE_W = 640
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  video_hsmooth3_if.slave  sink,
  video_hsmooth3_if.master source
);

  // x must hold IMAGE_W while flushing the last column.
  localparam int unsigned XW = $clog2(IMAGE_W + 1);
  localparam logic [XW-1:0] XLast = XW'(IMAGE_W - 1);

  typedef enum logic [2:0] {StDrop, StIdle, StPass, StV0, StRun, StFlush} state_e;

  state_e      state_q;
  logic [XW-1:0] x_q;
  logic [23:0] p1_q, p2_q;      // p1 = newest pixel, p2 = the one before
  logic        en_q;
  logic        last_eop_q;
  logic [23:0] out_data_q;
  logic        out_valid_q, out_sop_q, out_eop_q;

  logic        out_free, sink_rdy, accept;
  logic [23:0] left_px, run_px, flush_px;

  function automatic logic [23:0] smooth(input logic [23:0] l, input logic [23:0] c,
                                         input logic [23:0] r, input logic en);
    logic [23:0] o;
    logic [9:0]  s;
    o = c;
    if (en) begin
      for (int i = 0; i < 3; i++) begin
        s = {2'b00, l[8*i +: 8]} + {1'b0, c[8*i +: 8], 1'b0} + {2'b00, r[8*i +: 8]} + 10'd2;
        o[8*i +: 8] = 8'(s >> 2);
      end
    end
    return o;
  endfunction

  always_comb begin
    out_free = ~out_valid_q | source.ready;
    sink_rdy = out_free & (state_q != StFlush);
    accept   = sink.valid & sink_rdy;
    // Column being emitted is x-1; at column 0 the left neighbour is the pixel itself.
    left_px  = (x_q == XW'(1)) ? p1_q : p2_q;
    run_px   = smooth(left_px, p1_q, sink.data, en_q);
    flush_px = smooth(left_px, p1_q, p1_q, en_q);
  end

  assign sink.ready   = sink_rdy;
  assign source.data  = out_data_q;
  assign source.valid = out_valid_q;
  assign source.sop   = out_sop_q;
  assign source.eop   = out_eop_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StDrop;
      x_q         <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      en_q        <= 1'b0;
      last_eop_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      if (out_valid_q && source.ready) out_valid_q <= 1'b0;

      if (accept && sink.sop) begin
        // A sop always starts a new packet; any pending line state is abandoned.
        en_q        <= enable;
        x_q         <= '0;
        out_data_q  <= sink.data;
        out_sop_q   <= 1'b1;
        out_eop_q   <= sink.eop;
        out_valid_q <= 1'b1;
        if (sink.eop)                   state_q <= StIdle;
        else if (sink.data[3:0] == 4'h0) state_q <= StV0;
        else                            state_q <= StPass;
      end else if (accept) begin
        case (state_q)
          StPass, StIdle: begin
            out_data_q  <= sink.data;
            out_sop_q   <= 1'b0;
            out_eop_q   <= sink.eop;
            out_valid_q <= 1'b1;
            if (sink.eop) state_q <= StIdle;
          end
          StV0: begin
            p1_q       <= sink.data;
            x_q        <= XW'(1);
            last_eop_q <= sink.eop;
            state_q    <= sink.eop ? StFlush : StRun;
          end
          StRun: begin
            out_data_q  <= run_px;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_valid_q <= 1'b1;
            p2_q        <= p1_q;
            p1_q        <= sink.data;
            x_q         <= x_q + XW'(1);
            last_eop_q  <= sink.eop;
            if (x_q == XLast || sink.eop) state_q <= StFlush;
          end
          default: ;  // StDrop discards; StFlush never accepts
        endcase
      end else if (state_q == StFlush && out_free) begin
        out_data_q  <= flush_px;
        out_sop_q   <= 1'b0;
        out_eop_q   <= last_eop_q;
        out_valid_q <= 1'b1;
        if (last_eop_q) begin
          state_q <= StIdle;
        end else begin
          x_q     <= '0;
          state_q <= StV0;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_hsmooth3.sv
// Self-checking bench for video_hsmooth3 (IMAGE_W = 5): directed packet table, reset and
// stall corner cases, and a randomly back-pressured multi-line frame against a model.
module tb_video_hsmooth3;

  localparam int unsigned W = 5;
  localparam int unsigned H = 6;

  logic clk, reset_n, enable;
  video_hsmooth3_if sink_if ();
  video_hsmooth3_if src_if ();

  video_hsmooth3 #(.IMAGE_W(W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .sink   (sink_if),
    .source (src_if)
  );

  typedef struct {
    logic [23:0] din;
    logic        sop, eop, en;
    logic        has_exp;
    logic [25:0] exp;   // {sop, eop, data}
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [25:0] outq[$];
  vec_t        tbl[$];
  logic        bp_on = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source ready: random when back-pressure is on, otherwise always ready.
  initial begin
    src_if.ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      src_if.ready = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: collects transfers and checks hold-stability during stalls.
  initial begin
    logic        stall_prev;
    logic [25:0] held, cur;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cur = {src_if.sop, src_if.eop, src_if.data};
      if (reset_n && stall_prev) begin
        checks++;
        if (!src_if.valid || cur !== held) begin
          errors++;
          $display("FAIL hold_stable: got v=%0b %h required v=1 %h", src_if.valid, cur, held);
        end
      end
      stall_prev = reset_n && src_if.valid && !src_if.ready;
      held = cur;
      if (reset_n && src_if.valid && src_if.ready) outq.push_back(cur);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic send(input logic [23:0] d, input logic s, input logic e, input logic en);
    int   guard;
    logic ok;
    guard = 0;
    sink_if.data  = d;
    sink_if.sop   = s;
    sink_if.eop   = e;
    sink_if.valid = 1'b1;
    enable        = en;
    do begin
      ok = sink_if.ready;
      @(negedge clk);
      guard++;
    end while (!ok && guard < 1000);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready=0 required ready=1 within 1000 cycles");
    end
  endtask

  task automatic drain();
    int idle, guard;
    idle = 0;
    guard = 0;
    sink_if.valid = 1'b0;
    while (idle < 4 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (src_if.valid) idle = 0;
      else idle++;
    end
    if (idle < 4) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got source_valid busy required idle");
    end
  endtask

  task automatic cmp_queue(input string name, input logic [25:0] exp[$]);
    chk({name, "_count"}, outq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < outq.size(); i++)
      chk($sformatf("%s[%0d]", name, i), 32'(outq[i]), 32'(exp[i]));
  endtask

  task automatic add(input logic [23:0] din, input logic s, input logic e, input logic en,
                     input logic has, input logic es, input logic ee, input logic [23:0] ed);
    vec_t v;
    v.din = din; v.sop = s; v.eop = e; v.en = en;
    v.has_exp = has; v.exp = {es, ee, ed};
    tbl.push_back(v);
  endtask

  function automatic logic [23:0] model(input logic [23:0] l, input logic [23:0] c,
                                        input logic [23:0] r);
    logic [23:0] o;
    int s;
    for (int k = 0; k < 3; k++) begin
      s = int'(l[8*k +: 8]) + 2 * int'(c[8*k +: 8]) + int'(r[8*k +: 8]) + 2;
      o[8*k +: 8] = 8'(s / 4);
    end
    return o;
  endfunction

  task automatic reset_and_check(input string name);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({name, "_source_valid"}, 32'(src_if.valid), 32'd0);
    chk({name, "_sink_ready"}, 32'(sink_if.ready), 32'd1);
    chk({name, "_source_word"}, {6'd0, src_if.sop, src_if.eop, src_if.data}, 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [25:0] expq[$];
    logic [23:0] pix[W];

    sink_if.valid = 1'b0;
    sink_if.data  = '0;
    sink_if.sop   = 1'b0;
    sink_if.eop   = 1'b0;
    enable        = 1'b0;
    reset_and_check("reset");

    // Reset mid-frame, then headerless pixels must be dropped.
    send(24'h000000, 1'b1, 1'b0, 1'b1);
    send(24'h112233, 1'b0, 1'b0, 1'b1);
    send(24'h445566, 1'b0, 1'b0, 1'b1);
    sink_if.valid = 1'b0;
    reset_and_check("reset_midframe");
    outq.delete();
    send(24'h010203, 1'b0, 1'b0, 1'b1);
    send(24'h040506, 1'b0, 1'b0, 1'b1);
    send(24'h070809, 1'b0, 1'b1, 1'b1);
    drain();
    chk("drop_no_sop", outq.size(), 0);

    // Impulse line; enable changes on pixels but is only sampled at sop.
    add(24'h000000, 1, 0, 1, 1, 1, 0, 24'h000000);
    add(24'h000000, 0, 0, 0, 1, 0, 0, 24'h000000);
    add(24'h000000, 0, 0, 1, 1, 0, 0, 24'h404040);
    add(24'hFFFFFF, 0, 0, 0, 1, 0, 0, 24'h808080);
    add(24'h000000, 0, 0, 1, 1, 0, 0, 24'h404040);
    add(24'h000000, 0, 1, 0, 1, 0, 1, 24'h000000);
    // Short line with edge replication at both ends.
    add(24'h000000, 1, 0, 1, 1, 1, 0, 24'h000000);
    add(24'h646464, 0, 0, 1, 1, 0, 0, 24'h7D7D7D);
    add(24'hC8C8C8, 0, 0, 1, 1, 0, 0, 24'hAFAFAF);
    add(24'hC8C8C8, 0, 0, 1, 1, 0, 0, 24'hAFAFAF);
    add(24'h646464, 0, 1, 1, 1, 0, 1, 24'h7D7D7D);
    // Independent channels.
    add(24'h000000, 1, 0, 1, 1, 1, 0, 24'h000000);
    add(24'h400000, 0, 0, 1, 1, 0, 0, 24'h300010);
    add(24'h000040, 0, 0, 1, 1, 0, 0, 24'h103020);
    add(24'h00C000, 0, 1, 1, 1, 0, 1, 24'h009010);
    // Non-video packet forwarded bit-exact.
    add(24'h12345F, 1, 0, 1, 1, 1, 0, 24'h12345F);
    add(24'hABCDEF, 0, 0, 1, 1, 0, 0, 24'hABCDEF);
    add(24'h000001, 0, 0, 1, 1, 0, 0, 24'h000001);
    add(24'hFFFFFF, 0, 1, 1, 1, 0, 1, 24'hFFFFFF);
    // Bypass: enable=0 at sop.
    add(24'h000000, 1, 0, 0, 1, 1, 0, 24'h000000);
    add(24'h102030, 0, 0, 1, 1, 0, 0, 24'h102030);
    add(24'hFF00FF, 0, 0, 1, 1, 0, 0, 24'hFF00FF);
    add(24'h0A0B0C, 0, 1, 1, 1, 0, 1, 24'h0A0B0C);
    // Abort: second sop mid-line drops the pending column.
    add(24'h000000, 1, 0, 1, 1, 1, 0, 24'h000000);
    add(24'h080808, 0, 0, 1, 0, 0, 0, 24'h000000);
    add(24'h101010, 0, 0, 1, 1, 0, 0, 24'h0A0A0A);
    add(24'h000000, 1, 0, 1, 1, 1, 0, 24'h000000);
    add(24'h040404, 0, 0, 1, 1, 0, 0, 24'h060606);
    add(24'h0C0C0C, 0, 0, 1, 1, 0, 0, 24'h070707);
    add(24'h000000, 0, 1, 1, 1, 0, 1, 24'h030303);

    outq.delete();
    expq.delete();
    foreach (tbl[i]) begin
      send(tbl[i].din, tbl[i].sop, tbl[i].eop, tbl[i].en);
      if (tbl[i].has_exp) expq.push_back(tbl[i].exp);
    end
    drain();
    cmp_queue("table", expq);

    // Sink stalls for exactly one cycle after the last pixel of a line.
    outq.delete();
    send(24'h000000, 1'b1, 1'b0, 1'b1);
    send(24'h646464, 1'b0, 1'b0, 1'b1);
    send(24'hC8C8C8, 1'b0, 1'b0, 1'b1);
    send(24'hC8C8C8, 1'b0, 1'b0, 1'b1);
    chk("ready_before_last", 32'(sink_if.ready), 32'd1);
    send(24'h646464, 1'b0, 1'b1, 1'b1);
    chk("ready_flush_low", 32'(sink_if.ready), 32'd0);
    sink_if.valid = 1'b0;
    @(negedge clk);
    chk("ready_after_flush", 32'(sink_if.ready), 32'd1);
    drain();
    outq.delete();

    // Full-width lines under random back-pressure against the model.
    bp_on = 1'b1;
    expq.delete();
    send(24'h5A5A50, 1'b1, 1'b0, 1'b1);
    expq.push_back({2'b10, 24'h5A5A50});
    for (int y = 0; y < int'(H); y++) begin
      for (int x = 0; x < int'(W); x++) pix[x] = 24'($urandom);
      for (int x = 0; x < int'(W); x++)
        send(pix[x], 1'b0, (y == int'(H) - 1) && (x == int'(W) - 1), 1'b1);
      for (int x = 0; x < int'(W); x++)
        expq.push_back({1'b0, (y == int'(H) - 1) && (x == int'(W) - 1),
                        model(pix[(x == 0) ? 0 : x - 1], pix[x],
                              pix[(x == int'(W) - 1) ? x : x + 1])});
    end
    drain();
    bp_on = 1'b0;
    cmp_queue("frame", expq);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
